// File: rtl/prop_sequencer.sv
// rtl/prop_sequencer.sv - forward/backward propagation sequencer for a chain of unit layers
module prop_sequencer #(
  parameter int N_LAYERS = 4,
  parameter int LEN_W    = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         train_in,
  input  logic                         abort_in,
  input  logic [LEN_W-1:0]             stream_len_in,
  output logic [N_LAYERS-1:0]          fd_prop_out,
  output logic [N_LAYERS-1:0]          bk_prop_out,
  output logic                         oscillator_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         err_out,
  output logic [$clog2(N_LAYERS):0]    layer_out
);

  localparam int LAYER_W = $clog2(N_LAYERS) + 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE, FWD, FWD_GAP, BWD, BWD_GAP, DONE
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic               train_q;
  logic [LEN_W-1:0]   cnt;

  function automatic logic [N_LAYERS-1:0] one_hot(input logic [LAYER_W-1:0] idx);
    logic [N_LAYERS-1:0] r;
    for (int i = 0; i < N_LAYERS; i++) r[i] = (idx == LAYER_W'(i));
    return r;
  endfunction

  // Outputs are registered alongside the state so they reflect the state entered at each edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      len_q          <= '0;
      train_q        <= 1'b0;
      cnt            <= '0;
      fd_prop_out    <= '0;
      bk_prop_out    <= '0;
      oscillator_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      layer_out      <= '0;
    end else begin
      done_out <= 1'b0;
      err_out  <= 1'b0;
      if (state != IDLE && abort_in) begin
        state          <= IDLE;
        cnt            <= '0;
        fd_prop_out    <= '0;
        bk_prop_out    <= '0;
        oscillator_out <= 1'b0;
        busy_out       <= 1'b0;
        layer_out      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_in && !abort_in) begin
              if (stream_len_in != '0) begin
                len_q          <= stream_len_in;
                train_q        <= train_in;
                cnt            <= '0;
                layer_out      <= '0;
                fd_prop_out    <= one_hot('0);
                oscillator_out <= 1'b0;
                busy_out       <= 1'b1;
                state          <= FWD;
              end else begin
                err_out <= 1'b1;
              end
            end
          end
          FWD: begin
            // Terminal compare against len-1 so the maximum length never needs a wider counter.
            if (cnt == len_q - LEN_W'(1)) begin
              cnt            <= '0;
              fd_prop_out    <= '0;
              oscillator_out <= 1'b0;
              state          <= FWD_GAP;
            end else begin
              cnt            <= cnt + LEN_W'(1);
              oscillator_out <= ~oscillator_out;
            end
          end
          FWD_GAP: begin
            if (layer_out < LAST_LAYER) begin
              layer_out   <= layer_out + LAYER_W'(1);
              fd_prop_out <= one_hot(layer_out + LAYER_W'(1));
              state       <= FWD;
            end else if (train_q) begin
              bk_prop_out <= one_hot(layer_out);
              state       <= BWD;
            end else begin
              layer_out <= '0;
              busy_out  <= 1'b0;
              done_out  <= 1'b1;
              state     <= DONE;
            end
          end
          BWD: begin
            if (cnt == len_q - LEN_W'(1)) begin
              cnt            <= '0;
              bk_prop_out    <= '0;
              oscillator_out <= 1'b0;
              state          <= BWD_GAP;
            end else begin
              cnt            <= cnt + LEN_W'(1);
              oscillator_out <= ~oscillator_out;
            end
          end
          BWD_GAP: begin
            if (layer_out != '0) begin
              layer_out   <= layer_out - LAYER_W'(1);
              bk_prop_out <= one_hot(layer_out - LAYER_W'(1));
              state       <= BWD;
            end else begin
              busy_out <= 1'b0;
              done_out <= 1'b1;
              state    <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prop_sequencer.sv
// tb/tb_prop_sequencer.sv - self-checking bench for prop_sequencer against a cycle-index model
module tb_prop_sequencer;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int AW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          train;
  logic          abort;
  logic [LW-1:0] slen;
  logic [N-1:0]  fd_prop;
  logic [N-1:0]  bk_prop;
  logic          osc;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] layer;

  int checks = 0;
  int errors = 0;

  prop_sequencer #(.N_LAYERS(N), .LEN_W(LW)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .train_in      (train),
    .abort_in      (abort),
    .stream_len_in (slen),
    .fd_prop_out   (fd_prop),
    .bk_prop_out   (bk_prop),
    .oscillator_out(osc),
    .busy_out      (busy),
    .done_out      (done),
    .err_out       (err),
    .layer_out     (layer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs k cycles after an accepted start (k < 1 means idle).
  task automatic check_at(input string tag, input int len, input int tr, input int k);
    int seg, total, idx, j;
    logic [31:0] e_fd, e_bk, e_osc, e_busy, e_done, e_layer;
    seg   = len + 1;
    total = (tr != 0 ? 2 * N : N) * seg + 1;
    e_fd = 0; e_bk = 0; e_osc = 0; e_busy = 0; e_done = 0; e_layer = 0;
    if (k >= 1 && k < total) begin
      idx     = (k - 1) / seg;
      j       = (k - 1) % seg;
      e_busy  = 1;
      e_layer = (idx < N) ? idx : 2 * N - 1 - idx;
      if (j < len) begin
        if (idx < N) e_fd = 32'(1) << e_layer;
        else         e_bk = 32'(1) << e_layer;
        e_osc = j % 2;
      end
    end else if (k == total) begin
      e_done = 1;
    end
    chk({tag, ".fd"},    32'(fd_prop), e_fd);
    chk({tag, ".bk"},    32'(bk_prop), e_bk);
    chk({tag, ".osc"},   32'(osc),     e_osc);
    chk({tag, ".busy"},  32'(busy),    e_busy);
    chk({tag, ".done"},  32'(done),    e_done);
    chk({tag, ".layer"}, 32'(layer),   e_layer);
    chk({tag, ".err"},   32'(err),     0);
  endtask

  task automatic run_pass(input string tag, input int len, input int tr, input int abort_k, input int hold);
    int total, last;
    total = (tr != 0 ? 2 * N : N) * (len + 1) + 1;
    last  = (abort_k > 0) ? abort_k + 2 : total + 2;
    @(negedge clk);
    start = 1'b1; slen = LW'(len); train = 1'(tr);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (abort_k > 0 && k > abort_k) check_at(tag, len, tr, -1);
      else                            check_at(tag, len, tr, k);
      start = (hold != 0) && (k <= total);
      slen  = LW'($urandom);
      train = 1'($urandom);
      abort = (k == abort_k);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; train = 1'b0; abort = 1'b0; slen = '0;
    repeat (2) @(negedge clk);
    check_at("reset", 1, 0, -1);
    rst = 1'b0;

    run_pass("inf_len3", 3, 0, 0, 0);
    run_pass("trn_len3", 3, 1, 0, 0);
    run_pass("trn_len1", 1, 1, 0, 0);
    run_pass("inf_len4", 4, 0, 0, 0);

    @(negedge clk);
    start = 1'b1; slen = '0; train = 1'b1;
    @(negedge clk);
    chk("zero_len.err",  32'(err),     1);
    chk("zero_len.busy", 32'(busy),    0);
    chk("zero_len.fd",   32'(fd_prop), 0);
    chk("zero_len.bk",   32'(bk_prop), 0);
    start = 1'b0;
    @(negedge clk);
    check_at("zero_len_after", 1, 0, -1);

    run_pass("abort_bk1", 3, 1, 26, 0);
    run_pass("after_abort", 2, 0, 0, 0);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; slen = LW'(3);
    @(negedge clk);
    check_at("idle_abort_start", 3, 0, -1);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_at("idle_abort_start2", 3, 0, -1);

    run_pass("hold_start", 2, 1, 0, 1);
    run_pass("restart", 2, 0, 0, 0);

    run_pass("max_len", (1 << LW) - 1, 0, 0, 0);

    repeat (6) run_pass("rand", int'($urandom_range(1, 6)), int'($urandom_range(0, 1)), 0, 0);

    @(negedge clk);
    start = 1'b1; slen = LW'(5); train = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_at("rst_mid", 5, 1, -1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_at("rst_mid_after", 5, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
